// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the core.
//   Holds the fetch PC and selects the next PC. Redirect priority is
//   jr > jump > branch > sequential. A redirect that arrives during a stall
//   is held in a pending register and is applied when the stall drops.
//   A redirect to a target that is not word-aligned traps to EXC_VECTOR.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   stall                       hold the PC for this cycle
//   branch_taken/branch_offset  conditional branch, signed word offset
//   jump/jump_target            j/jal target from the jump-address concatenator
//   jr/jr_addr                  jump-register target
//   pc_out                      registered fetch PC
//   pc_plus4, pc_hi             combinational PC+4 and its upper nibble
//   valid                       pc_out is a live fetch address
//   flush                       one-cycle pulse when the PC was redirected
//   misalign                    one-cycle pulse when a trap is taken
//   bad_addr                    offending target of the most recent trap
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [3:0]  pc_hi,
    output logic        valid,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] bad_addr
);

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic        pend_valid_q;
    logic        valid_q;
    logic        flush_q;
    logic        misalign_q;
    logic [31:0] bad_addr_q;

    logic [31:0] branch_tgt_d;
    logic [31:0] req_tgt_d;
    logic        req_any_d;
    logic [31:0] apply_tgt_d;
    logic        apply_d;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_hi    = pc_plus4[31:28];
    assign pc_out   = pc_q;
    assign valid    = valid_q;
    assign flush    = flush_q;
    assign misalign = misalign_q;
    assign bad_addr = bad_addr_q;

    always_comb begin
        branch_tgt_d = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        req_any_d    = jr | jump | branch_taken;
        if (jr)
            req_tgt_d = jr_addr;
        else if (jump)
            req_tgt_d = jump_target;
        else
            req_tgt_d = branch_tgt_d;
        // A buffered redirect outranks live inputs: those come from
        // instructions that the buffered redirect squashes.
        if (pend_valid_q) begin
            apply_tgt_d = pend_q;
            apply_d     = 1'b1;
        end else begin
            apply_tgt_d = req_tgt_d;
            apply_d     = req_any_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            valid_q      <= 1'b0;
            flush_q      <= 1'b0;
            misalign_q   <= 1'b0;
            bad_addr_q   <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q    <= RUN;
                    valid_q    <= 1'b1;
                    flush_q    <= 1'b0;
                    misalign_q <= 1'b0;
                end
                RUN: begin
                    flush_q    <= 1'b0;
                    misalign_q <= 1'b0;
                    if (stall) begin
                        // First redirect seen during a stall wins.
                        if (req_any_d && !pend_valid_q) begin
                            pend_q       <= req_tgt_d;
                            pend_valid_q <= 1'b1;
                        end
                    end else begin
                        pend_valid_q <= 1'b0;
                        if (apply_d) begin
                            flush_q <= 1'b1;
                            if (apply_tgt_d[1:0] == 2'b00) begin
                                pc_q <= apply_tgt_d;
                            end else begin
                                state_q    <= TRAP;
                                pc_q       <= EXC_VECTOR;
                                misalign_q <= 1'b1;
                                bad_addr_q <= apply_tgt_d;
                            end
                        end else begin
                            pc_q <= pc_plus4;
                        end
                    end
                end
                TRAP: begin
                    state_q    <= RUN;
                    flush_q    <= 1'b0;
                    misalign_q <= 1'b0;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [3:0]  pc_hi;
    logic        valid;
    logic        flush;
    logic        misalign;
    logic [31:0] bad_addr;

    typedef struct packed {
        logic [31:0] pc;
        logic        fl;
        logic        mis;
        logic        vld;
    } obs_t;

    typedef struct packed {
        logic        st;
        logic        br;
        logic [15:0] off;
        logic        j;
        logic [31:0] jt;
        logic        r;
        logic [31:0] ra;
        obs_t        e;
    } step_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    pc_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR  (32'h0000_0080)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .pc_hi        (pc_hi),
        .valid        (valid),
        .flush        (flush),
        .misalign     (misalign),
        .bad_addr     (bad_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic step_t stp(input logic st, input logic br, input logic [15:0] off,
                                  input logic j, input logic [31:0] jt,
                                  input logic r, input logic [31:0] ra,
                                  input logic [31:0] epc, input logic efl, input logic emis);
        step_t s;
        s.st = st; s.br = br; s.off = off; s.j = j; s.jt = jt; s.r = r; s.ra = ra;
        s.e.pc = epc; s.e.fl = efl; s.e.mis = emis; s.e.vld = 1'b1;
        return s;
    endfunction

    task automatic drive(input step_t s);
        stall = s.st; branch_taken = s.br; branch_offset = s.off;
        jump = s.j; jump_target = s.jt; jr = s.r; jr_addr = s.ra;
    endtask

    // Drive at posedge+1, sample at the following posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t steps[$];
        obs_t  got, obs;
        rst_n = 1'b0;
        drive(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
        #12;
        n_checks++;
        if ({pc_out, valid, flush, misalign, bad_addr} !== {32'h0, 3'b000, 32'h0}) begin
            n_fails++;
            $display("FAIL reset_state: pc=%h valid=%b flush=%b mis=%b bad=%h, required pc=0 valid=0 flush=0 mis=0 bad=0",
                     pc_out, valid, flush, misalign, bad_addr);
        end
        #10 rst_n = 1'b1;
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0, 32'h4, 0, 0));
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0, 32'h8, 0, 0));
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0, 32'hC, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb.push_back(steps[i].e);
            tick();
            got = sb.pop_front();
            obs = '{pc_out, flush, misalign, valid};
            n_checks++;
            if (obs !== got) begin
                n_fails++;
                $display("FAIL boot step %0d: pc=%h fl=%b mis=%b vld=%b, required pc=%h fl=%b mis=%b vld=%b",
                         i, obs.pc, obs.fl, obs.mis, obs.vld, got.pc, got.fl, got.mis, got.vld);
            end
        end
        n_checks++;
        if (pc_hi !== 4'h0) begin
            n_fails++;
            $display("FAIL boot_pc_hi: got %h, required 0", pc_hi);
        end
    endtask

    task automatic test_jump();
        step_t steps[$];
        obs_t  got, obs;
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0,         1, 32'hA000_0010, 32'hA000_0010, 1, 0));
        steps.push_back(stp(0, 0, 16'h0, 1, 32'hA3AB_9998, 0, 32'h0,         32'hA3AB_9998, 1, 0));
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0,         0, 32'h0,         32'hA3AB_999C, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb.push_back(steps[i].e);
            tick();
            got = sb.pop_front();
            obs = '{pc_out, flush, misalign, valid};
            n_checks++;
            if (obs !== got) begin
                n_fails++;
                $display("FAIL jump step %0d: pc=%h fl=%b mis=%b vld=%b, required pc=%h fl=%b mis=%b vld=%b",
                         i, obs.pc, obs.fl, obs.mis, obs.vld, got.pc, got.fl, got.mis, got.vld);
            end
            if (i == 0) begin
                n_checks++;
                if (pc_hi !== 4'hA) begin
                    n_fails++;
                    $display("FAIL jump_pc_hi: got %h, required a", pc_hi);
                end
            end
        end
    endtask

    task automatic test_branch();
        step_t steps[$];
        obs_t  got, obs;
        steps.push_back(stp(0, 0, 16'h0,    0, 32'h0, 1, 32'h100, 32'h100, 1, 0));
        steps.push_back(stp(0, 1, 16'h0003, 0, 32'h0, 0, 32'h0,   32'h110, 1, 0));
        steps.push_back(stp(0, 0, 16'h0,    0, 32'h0, 1, 32'h100, 32'h100, 1, 0));
        steps.push_back(stp(0, 1, 16'hFFFE, 0, 32'h0, 0, 32'h0,   32'h0FC, 1, 0));
        steps.push_back(stp(0, 0, 16'h0,    0, 32'h0, 0, 32'h0,   32'h100, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb.push_back(steps[i].e);
            tick();
            got = sb.pop_front();
            obs = '{pc_out, flush, misalign, valid};
            n_checks++;
            if (obs !== got) begin
                n_fails++;
                $display("FAIL branch step %0d: pc=%h fl=%b mis=%b vld=%b, required pc=%h fl=%b mis=%b vld=%b",
                         i, obs.pc, obs.fl, obs.mis, obs.vld, got.pc, got.fl, got.mis, got.vld);
            end
        end
    endtask

    task automatic test_priority();
        step_t steps[$];
        obs_t  got, obs;
        steps.push_back(stp(0, 1, 16'h0005, 1, 32'h800, 1, 32'h400, 32'h400, 1, 0));
        steps.push_back(stp(0, 1, 16'h0005, 1, 32'h800, 0, 32'h0,   32'h800, 1, 0));
        steps.push_back(stp(0, 0, 16'h0,    0, 32'h0,   1, 32'h400, 32'h400, 1, 0));
        steps.push_back(stp(0, 0, 16'h0,    0, 32'h0,   0, 32'h0,   32'h404, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb.push_back(steps[i].e);
            tick();
            got = sb.pop_front();
            obs = '{pc_out, flush, misalign, valid};
            n_checks++;
            if (obs !== got) begin
                n_fails++;
                $display("FAIL priority step %0d: pc=%h fl=%b mis=%b vld=%b, required pc=%h fl=%b mis=%b vld=%b",
                         i, obs.pc, obs.fl, obs.mis, obs.vld, got.pc, got.fl, got.mis, got.vld);
            end
        end
    endtask

    // From pc=0x404 a branch offset of -0x82 words lands on 0x200.
    task automatic test_stall();
        step_t steps[$];
        obs_t  got, obs;
        steps.push_back(stp(1, 1, 16'hFF7E, 0, 32'h0, 0, 32'h0,   32'h404, 0, 0));
        steps.push_back(stp(1, 0, 16'h0,    0, 32'h0, 1, 32'h300, 32'h404, 0, 0));
        steps.push_back(stp(1, 0, 16'h0,    0, 32'h0, 0, 32'h0,   32'h404, 0, 0));
        steps.push_back(stp(0, 0, 16'h0,    0, 32'h0, 1, 32'h500, 32'h200, 1, 0));
        steps.push_back(stp(0, 0, 16'h0,    0, 32'h0, 0, 32'h0,   32'h204, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb.push_back(steps[i].e);
            tick();
            got = sb.pop_front();
            obs = '{pc_out, flush, misalign, valid};
            n_checks++;
            if (obs !== got) begin
                n_fails++;
                $display("FAIL stall step %0d: pc=%h fl=%b mis=%b vld=%b, required pc=%h fl=%b mis=%b vld=%b",
                         i, obs.pc, obs.fl, obs.mis, obs.vld, got.pc, got.fl, got.mis, got.vld);
            end
        end
    endtask

    task automatic test_misalign();
        step_t       steps[$];
        obs_t        got, obs;
        logic [31:0] bad_exp[$];
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 1, 32'h1002, 32'h80, 1, 1)); bad_exp.push_back(32'h1002);
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 1, 32'h600,  32'h80, 0, 0)); bad_exp.push_back(32'h1002);
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0,    32'h84, 0, 0)); bad_exp.push_back(32'h1002);
        steps.push_back(stp(1, 0, 16'h0, 0, 32'h0, 1, 32'h3,    32'h84, 0, 0)); bad_exp.push_back(32'h1002);
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0,    32'h80, 1, 1)); bad_exp.push_back(32'h3);
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0,    32'h80, 0, 0)); bad_exp.push_back(32'h3);
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0,    32'h84, 0, 0)); bad_exp.push_back(32'h3);
        foreach (steps[i]) begin
            drive(steps[i]);
            sb.push_back(steps[i].e);
            tick();
            got = sb.pop_front();
            obs = '{pc_out, flush, misalign, valid};
            n_checks++;
            if (obs !== got) begin
                n_fails++;
                $display("FAIL misalign step %0d: pc=%h fl=%b mis=%b vld=%b, required pc=%h fl=%b mis=%b vld=%b",
                         i, obs.pc, obs.fl, obs.mis, obs.vld, got.pc, got.fl, got.mis, got.vld);
            end
            n_checks++;
            if (bad_addr !== bad_exp[i]) begin
                n_fails++;
                $display("FAIL bad_addr step %0d: got %h, required %h", i, bad_addr, bad_exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        step_t steps[$];
        obs_t  got, obs;
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0));
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0,         32'h0,         0, 0));
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0,         32'h4,         0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb.push_back(steps[i].e);
            tick();
            got = sb.pop_front();
            obs = '{pc_out, flush, misalign, valid};
            n_checks++;
            if (obs !== got) begin
                n_fails++;
                $display("FAIL wrap step %0d: pc=%h fl=%b mis=%b vld=%b, required pc=%h fl=%b mis=%b vld=%b",
                         i, obs.pc, obs.fl, obs.mis, obs.vld, got.pc, got.fl, got.mis, got.vld);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t steps[$];
        obs_t  got, obs;
        // Capture a pending jr during a stall, then reset before it applies.
        steps.push_back(stp(1, 0, 16'h0, 0, 32'h0, 1, 32'h700, 32'h4, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb.push_back(steps[i].e);
            tick();
            got = sb.pop_front();
            obs = '{pc_out, flush, misalign, valid};
            n_checks++;
            if (obs !== got) begin
                n_fails++;
                $display("FAIL rst_stall step %0d: pc=%h fl=%b mis=%b vld=%b, required pc=%h fl=%b mis=%b vld=%b",
                         i, obs.pc, obs.fl, obs.mis, obs.vld, got.pc, got.fl, got.mis, got.vld);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pc_out, valid, flush} !== {32'h0, 2'b00}) begin
            n_fails++;
            $display("FAIL async_reset: pc=%h valid=%b flush=%b, required pc=0 valid=0 flush=0",
                     pc_out, valid, flush);
        end
        drive(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        #4;
        steps.delete();
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0, 32'h4, 0, 0));
        steps.push_back(stp(0, 0, 16'h0, 0, 32'h0, 0, 32'h0, 32'h8, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb.push_back(steps[i].e);
            tick();
            got = sb.pop_front();
            obs = '{pc_out, flush, misalign, valid};
            n_checks++;
            if (obs !== got) begin
                n_fails++;
                $display("FAIL rst_reboot step %0d: pc=%h fl=%b mis=%b vld=%b, required pc=%h fl=%b mis=%b vld=%b",
                         i, obs.pc, obs.fl, obs.mis, obs.vld, got.pc, got.fl, got.mis, got.vld);
            end
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_branch();
        test_priority();
        test_stall();
        test_misalign();
        test_wrap();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
